arb_muxn: RTL and testbench
===========================

Name: arb_muxn

Overview:
- Parametrised N-channel successor of the 3-input select mux.
- Arbitrates among N valid/ready producers, for example ALU, load unit and CSR results competing for writeback.
- Registers the winning beat into a one-entry output stage and presents it downstream with valid/ready.
- Selection is by an internal arbiter rather than an external select, in fixed-priority or round-robin mode.

Parameters:
- WIDTH, 32, data width per channel.
- N, 3, number of input channels; legal range N >= 2.
- RR, 0, arbitration mode: 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N  per-channel beat valid.
- in_ready  output  N  per-channel accept; at most one bit set per cycle.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accept.
- out_data  output  WIDTH  registered winning data.
- out_sel  output  SELW  index of the channel that produced out_data; SELW = max(1, clog2(N)).

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer=0.
  - Any held beat is discarded.
- While rst is high, in_ready=0 (combinational gate on rst).
- Load condition: load = !rst & (|in_valid) & (!out_valid | out_ready).
- Grant, combinational from in_valid and the pointer:
  - RR=0: highest-index valid channel wins. With all channels valid, channel N-1 is chosen, matching the legacy mux precedence.
  - RR=1: first valid channel at or above ptr, searching upward and wrapping modulo N.
- in_ready = grant & {N{load}}. A beat transfers on channel i when in_valid[i] & in_ready[i].
- On load:
  - out_data <= in_data[g].
  - out_sel <= g.
  - out_valid <= 1.
  - RR=1 only: ptr <= (g == N-1) ? 0 : g+1.
- Otherwise, if out_valid & out_ready: out_valid <= 0. out_data and out_sel hold their last values.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 beat per cycle when out_ready is held high, because a simultaneous drain and load is permitted.
- Stall: when out_valid=1 and out_ready=0, out_data, out_sel and ptr hold, and all in_ready=0.
- No valid input: ptr does not move and out_valid clears if drained.
- Inputs may withdraw in_valid without a handshake. The arbiter is re-evaluated every cycle and grants are not sticky.
- A single valid channel in RR=1 mode is granted every cycle regardless of ptr.
- Unused out_sel upper codes (N not a power of 2) are never produced.

Optional Feature:
- Macro: ARB_MUXN_SKID_EN.
- Defined:
  - Adds a one-entry skid buffer behind the output register.
  - in_ready no longer depends combinationally on out_ready. load = !rst & (|in_valid) & !skid_valid.
  - A beat accepted while the output is stalled goes to the skid buffer and is promoted to the output register when it drains.
  - Order of beats is preserved.
  - Reset clears skid_valid.
  - Full throughput is retained.
- Undefined: behaviour exactly as described above, with the combinational out_ready -> in_ready path.

Decomposition:
- Shared package arb_muxn_pkg holds:
  - constants ARB_FIXED=0 and ARB_RR=1;
  - a function computing SELW;
  - a function for the fixed-priority one-hot to index encoding.
- One natural sub-module: arb_rr_pick (N, pointer input; one-hot grant and index output). It also covers the fixed mode with the pointer tied to 0 and reversed priority, or via a generate branch.

Test Plan:
- All tests use N=3, WIDTH=32.
- Reset with all in_valid=1 and rst=1:
  - During rst: in_ready=000.
  - After rst drops: out_valid=0, out_data=0.
  - One cycle later, RR=0: out_data=d2 and out_sel=2.
- RR=0, in_valid=011, d0=0x11, d1=0x22, out_ready=1:
  - in_ready=010.
  - Next cycle out_data=0x22, out_sel=1.
- RR=1, in_valid=111 held, out_ready=1 for 6 cycles:
  - out_sel sequence 0,1,2,0,1,2.
  - Each in_ready bit pulses once per 3 cycles.
- Backpressure: out_ready=0 after the first beat, for 4 cycles:
  - out_data is stable and in_ready=000.
  - Release: beats resume, none lost or duplicated (scoreboard on data tags 0xA0..0xA7).
- Reset mid-stall (out_valid=1, out_ready=0, assert rst 1 cycle): out_valid=0 and ptr=0 the next cycle; the held beat never appears.
- With ARB_MUXN_SKID_EN: out_ready toggling 1,0,1,0 against continuous single-channel input:
  - all 8 beats 0x00..0x07 are delivered in order;
  - in_ready never combinationally follows out_ready (assertion).

Source files
------------

// File: rtl/arb_muxn_pkg.sv
// arb_muxn_pkg: shared arbitration constants and helpers for arb_muxn
package arb_muxn_pkg;
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    // width of a channel index, never below one bit
    function automatic int sel_w(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction
    // index of the set bit of a one-hot vector (up to 64 channels)
    function automatic int onehot_idx(input logic [63:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 64; i++) r = oh[i] ? i : r;
        return r;
    endfunction
endpackage

// File: rtl/arb_muxn_pick.sv
// arb_rr_pick: one-hot grant and index among N requesters, fixed-priority or round-robin
//   valid : per-channel request
//   ptr   : round-robin start channel (ignored in fixed mode)
//   grant : one-hot winner, zero when nothing is valid
//   idx   : index of the winner
module arb_rr_pick import arb_muxn_pkg::*; #(
    parameter int N    = 3,
    parameter int RR   = ARB_FIXED,
    parameter int SELW = sel_w(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx
);
    int d;
    int best;
    always_comb begin
        grant = '0;
        idx = '0;
        d = 0;
        best = N;
        if (RR == ARB_RR) begin
            // winner is the valid channel with the smallest upward distance from ptr
            for (int i = 0; i < N; i++) begin
                d = (i >= int'(ptr)) ? i - int'(ptr) : i + N - int'(ptr);
                if (valid[i] && d < best) begin
                    best = d;
                    grant = '0;
                    grant[i] = 1'b1;
                    idx = SELW'(i);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (valid[i]) begin
                    grant = '0;
                    grant[i] = 1'b1;
                end
            end
            idx = SELW'(onehot_idx(64'(grant)));
        end
    end
endmodule

// File: rtl/arb_muxn.sv
// arb_muxn: N-channel valid/ready arbiter with a registered one-entry output stage
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : per-channel handshake, at most one in_ready bit set
//   in_data            : channel i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready: downstream handshake
//   out_data, out_sel  : registered winning beat and its channel index
//   ARB_MUXN_SKID_EN   : adds a skid entry so in_ready does not depend on out_ready
module arb_muxn import arb_muxn_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int N     = 3,
    parameter int RR    = ARB_FIXED,
    localparam int SELW = sel_w(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel
);
    logic [N-1:0]     grant;
    logic [SELW-1:0]  gidx;
    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  ptr_nx;
    logic [WIDTH-1:0] gdata;
    logic             load;
    arb_rr_pick #(.N(N), .RR(RR), .SELW(SELW)) u_pick (
        .valid(in_valid),
        .ptr  (ptr),
        .grant(grant),
        .idx  (gidx)
    );
    always_comb begin
        gdata = '0;
        for (int i = 0; i < N; i++) gdata = grant[i] ? in_data[i*WIDTH +: WIDTH] : gdata;
    end
    assign ptr_nx   = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
    assign in_ready = grant & {N{load}};
`ifdef ARB_MUXN_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic [SELW-1:0]  skid_sel;
    assign load = !rst && (|in_valid) && !skid_valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= '0;
            skid_valid <= 1'b0;
            ptr        <= '0;
        end else begin
            if (load && RR == ARB_RR) ptr <= ptr_nx;
            if (!out_valid || out_ready) begin
                // the skid entry is older than any new beat, so it is promoted first
                out_valid <= skid_valid || load;
                if (skid_valid) begin
                    out_data   <= skid_data;
                    out_sel    <= skid_sel;
                    skid_valid <= 1'b0;
                end else if (load) begin
                    out_data <= gdata;
                    out_sel  <= gidx;
                end
            end else if (load) begin
                skid_data  <= gdata;
                skid_sel   <= gidx;
                skid_valid <= 1'b1;
            end
        end
    end
`else
    assign load = !rst && (|in_valid) && (!out_valid || out_ready);
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= gdata;
            out_sel   <= gidx;
            if (RR == ARB_RR) ptr <= ptr_nx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_arb_muxn.sv
// tb_arb_muxn: randomized and directed checks of arb_muxn (fixed and round-robin) against a queue model
module tb_arb_muxn;
    localparam int W = 32;
`ifdef ARB_MUXN_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           oready = 1'b0;
    logic [2:0]     iv = '0;
    logic [3*W-1:0] id = '0;
    logic [2:0]     ir0, ir1;
    logic           ov0, ov1;
    logic [W-1:0]   od0, od1;
    logic [1:0]     os0, os1;
    int errors = 0;
    int checks = 0;
    int cnt[2] = '{0, 0};
    int mp[2] = '{0, 0};
    int ms[2] = '{0, 0};
    logic [W-1:0] md[2] = '{0, 0};
    logic [W-1:0] qd[2][2];
    int qs[2][2];

    always #5 clk = ~clk;

    arb_muxn #(.WIDTH(W), .N(3), .RR(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir0), .in_data(id),
        .out_valid(ov0), .out_ready(oready), .out_data(od0), .out_sel(os0)
    );
    arb_muxn #(.WIDTH(W), .N(3), .RR(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir1), .in_data(id),
        .out_valid(ov1), .out_ready(oready), .out_data(od1), .out_sel(os1)
    );

    // model m=0 is fixed priority (highest index), m=1 is round-robin from mp[1]
    function automatic int pick(int m, logic [2:0] v);
        if (m == 0) begin
            for (int i = 2; i >= 0; i--) if (v[i]) return i;
        end else begin
            for (int k = 0; k < 3; k++) if (v[(mp[1] + k) % 3]) return (mp[1] + k) % 3;
        end
        return -1;
    endfunction

    // output stage holds one beat, or two with the skid entry
    function automatic bit can_ld(int m);
        return SKID ? (cnt[m] < 2) : (cnt[m] == 0 || oready);
    endfunction

    function automatic logic [2:0] exp_ready(int m);
        int g;
        g = pick(m, iv);
        return (rst || g < 0 || !can_ld(m)) ? 3'b000 : 3'(1 << g);
    endfunction

    function automatic logic [34:0] exp_out(int m);
        return {cnt[m] > 0, 2'(ms[m]), md[m]};
    endfunction

    task automatic model_clk(int m);
        int g;
        bit ld;
        if (rst) begin
            cnt[m] = 0; md[m] = '0; ms[m] = 0; mp[m] = 0;
            return;
        end
        g = pick(m, iv);
        ld = g >= 0 && can_ld(m);
        if (oready && cnt[m] > 0) begin
            qd[m][0] = qd[m][1];
            qs[m][0] = qs[m][1];
            cnt[m]--;
        end
        if (ld) begin
            qd[m][cnt[m]] = id[g*W +: W];
            qs[m][cnt[m]] = g;
            cnt[m]++;
            if (m == 1) mp[1] = (g + 1) % 3;
        end
        if (cnt[m] > 0) begin
            md[m] = qd[m][0];
            ms[m] = qs[m][0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clk(0);
        model_clk(1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; iv = 3'b111; oready = 1'b1; id = {32'hD2, 32'hD1, 32'hD0};
        #1;
        checks++;
        if (ir0 !== 3'b000 || ir1 !== 3'b000) begin errors++; $display("FAIL reset_in_ready got %b/%b want 000", ir0, ir1); end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({ov0, od0, ov1, od1} !== 66'd0) begin errors++; $display("FAIL reset_out got %b %h %b %h want all zero", ov0, od0, ov1, od1); end
        checks++;
        if (ir0 !== 3'b100) begin errors++; $display("FAIL reset_first_grant got %b want 100", ir0); end
        tick();
        checks++;
        if ({ov0, os0, od0} !== {1'b1, 2'd2, 32'hD2}) begin errors++; $display("FAIL reset_first_beat_fixed got %b %0d %h want 1 2 d2", ov0, os0, od0); end
        checks++;
        if ({ov1, os1, od1} !== {1'b1, 2'd0, 32'hD0}) begin errors++; $display("FAIL reset_first_beat_rr got %b %0d %h want 1 0 d0", ov1, os1, od1); end
    endtask

    task automatic test_fixed_priority();
        iv = 3'b011; id = {32'h33, 32'h22, 32'h11}; oready = 1'b1;
        #1;
        checks++;
        if (ir0 !== 3'b010) begin errors++; $display("FAIL fixed_ready got %b want 010", ir0); end
        checks++;
        if (ir1 !== exp_ready(1)) begin errors++; $display("FAIL fixed_rr_ready got %b want %b", ir1, exp_ready(1)); end
        tick();
        checks++;
        if ({ov0, os0, od0} !== {1'b1, 2'd1, 32'h22}) begin errors++; $display("FAIL fixed_out got %b %0d %h want 1 1 22", ov0, os0, od0); end
        checks++;
        if ({ov1, os1, od1} !== exp_out(1)) begin errors++; $display("FAIL fixed_rr_out got %h want %h", {ov1, os1, od1}, exp_out(1)); end
    endtask

    task automatic test_round_robin();
        do_reset();
        iv = 3'b111; oready = 1'b1; id = {32'hC2, 32'hC1, 32'hC0};
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (ir1 !== 3'(1 << (i % 3))) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", i, ir1, 3'(1 << (i % 3))); end
            tick();
            checks++;
            if ({ov1, os1, od1} !== {1'b1, 2'(i % 3), 32'hC0 + 32'(i % 3)}) begin errors++; $display("FAIL rr_sel[%0d] got %0d want %0d", i, os1, i % 3); end
            checks++;
            if ({ov0, os0, od0} !== exp_out(0)) begin errors++; $display("FAIL rr_fixed_out[%0d] got %h want %h", i, {ov0, os0, od0}, exp_out(0)); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] seen;
        int got;
        int k[3];
        seen = '0; got = 0; k = '{0, 0, 0};
        do_reset();
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            oready = !(cyc >= 1 && cyc <= 4);
            for (int c = 0; c < 3; c++) begin
                iv[c] = (c + 3 * k[c]) < 8;
                id[c*W +: W] = 32'hA0 + 32'(c + 3 * k[c]);
            end
            #1;
            checks++;
            if (ir0 !== exp_ready(0) || ir1 !== exp_ready(1)) begin errors++; $display("FAIL bp_ready[%0d] got %b/%b want %b/%b", cyc, ir0, ir1, exp_ready(0), exp_ready(1)); end
            if (cyc >= 1 && cyc <= 4) begin
                checks++;
                if ({ov1, od1} !== {1'b1, 32'hA0}) begin errors++; $display("FAIL bp_stall_hold[%0d] got %b %h want 1 a0", cyc, ov1, od1); end
`ifndef ARB_MUXN_SKID_EN
                checks++;
                if (ir1 !== 3'b000) begin errors++; $display("FAIL bp_stall_ready[%0d] got %b want 000", cyc, ir1); end
`endif
            end
            if (ov1 && oready) begin
                checks++;
                if (od1 < 32'hA0 || od1 > 32'hA7 || seen[od1[2:0]]) begin errors++; $display("FAIL bp_tag got %h want unseen a0..a7", od1); end
                else seen[od1[2:0]] = 1'b1;
                got++;
            end
            for (int c = 0; c < 3; c++) if (iv[c] && ir1[c]) k[c]++;
            tick();
            checks++;
            if ({ov0, os0, od0, ov1, os1, od1} !== {exp_out(0), exp_out(1)}) begin errors++; $display("FAIL bp_out[%0d] got %h want %h", cyc, {ov0, os0, od0, ov1, os1, od1}, {exp_out(0), exp_out(1)}); end
        end
        checks++;
        if (got !== 8 || seen !== 8'hFF) begin errors++; $display("FAIL bp_delivered got %0d mask %b want 8 11111111", got, seen); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        oready = 1'b0; iv = 3'b001; id = {64'd0, 32'hDEAD};
        tick();
        id = {64'd0, 32'hBEEF};
        tick();
        iv = 3'b000;
        checks++;
        if ({ov1, od1} !== {1'b1, 32'hDEAD}) begin errors++; $display("FAIL stall_setup got %b %h want 1 dead", ov1, od1); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ov0 !== 1'b0 || ov1 !== 1'b0) begin errors++; $display("FAIL stall_reset_valid got %b/%b want 0/0", ov0, ov1); end
        iv = 3'b111; id = {32'h33, 32'h22, 32'h11}; oready = 1'b1;
        tick();
        checks++;
        if ({ov1, os1, od1} !== {1'b1, 2'd0, 32'h11}) begin errors++; $display("FAIL stall_reset_ptr got %b %0d %h want 1 0 11", ov1, os1, od1); end
        iv = 3'b000;
        tick();
        checks++;
        if (ov0 !== 1'b0 || ov1 !== 1'b0) begin errors++; $display("FAIL stall_discard got %b/%b want 0/0", ov0, ov1); end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            iv = 3'($urandom);
            id = {$urandom, $urandom, $urandom};
            oready = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 31) == 0;
            #1;
            checks++;
            if (ir0 !== exp_ready(0) || ir1 !== exp_ready(1)) begin errors++; $display("FAIL rand_ready[%0d] got %b/%b want %b/%b", cyc, ir0, ir1, exp_ready(0), exp_ready(1)); end
            tick();
            checks++;
            if ({ov0, os0, od0, ov1, os1, od1} !== {exp_out(0), exp_out(1)}) begin errors++; $display("FAIL rand_out[%0d] got %h want %h", cyc, {ov0, os0, od0, ov1, os1, od1}, {exp_out(0), exp_out(1)}); end
        end
        rst = 1'b0;
    endtask

`ifdef ARB_MUXN_SKID_EN
    task automatic test_skid();
        int tag;
        int got;
        logic [2:0] a;
        tag = 0; got = 0;
        do_reset();
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            oready = (cyc % 2) == 0;
            iv = (tag < 8) ? 3'b001 : 3'b000;
            id = {64'd0, 32'(tag)};
            #1;
            a = ir1;
            oready = ~oready;
            #1;
            checks++;
            if (ir1 !== a) begin errors++; $display("FAIL skid_comb_path[%0d] got %b want %b", cyc, ir1, a); end
            oready = ~oready;
            #1;
            checks++;
            if (ir1 !== exp_ready(1)) begin errors++; $display("FAIL skid_ready[%0d] got %b want %b", cyc, ir1, exp_ready(1)); end
            if (ov1 && oready) begin
                checks++;
                if (od1 !== 32'(got)) begin errors++; $display("FAIL skid_order got %h want %h", od1, got); end
                got++;
            end
            if (iv[0] && ir1[0]) tag++;
            tick();
            checks++;
            if ({ov1, os1, od1} !== exp_out(1)) begin errors++; $display("FAIL skid_out[%0d] got %h want %h", cyc, {ov1, os1, od1}, exp_out(1)); end
        end
        checks++;
        if (got !== 8) begin errors++; $display("FAIL skid_delivered got %0d want 8", got); end
    endtask
`endif

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_backpressure();
        test_reset_mid_stall();
        test_random();
`ifdef ARB_MUXN_SKID_EN
        test_skid();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
